// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned ADDR_W_DEF    = 16;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHK,
    DONE,
    ERROR
  } state_t;

  // One instruction word as it travels to the code memory.
  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } word_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and code-memory write port of the program loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // Loader side: consumes the byte stream, drives the memory write port.
  modport master (
    input  rx_valid, rx_data,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  // Environment side: byte source and code memory.
  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/word_asm.sv
// Pairs hi/lo bytes into 16-bit words and keeps a running XOR over payload bytes.
module word_asm
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_stb,
  input  logic              sel_hi,
  input  logic [BYTE_W-1:0] byte_in,
  output word_t             word,
  output logic              word_valid,
  output logic [BYTE_W-1:0] chk
);

  logic [BYTE_W-1:0] hi_q;

  // word/word_valid appear the cycle after the lo byte; word holds between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      chk        <= '0;
    end else begin
      word_valid <= byte_stb && !sel_hi;
      if (clr) begin
        chk <= '0;
      end else if (byte_stb) begin
        chk <= chk ^ byte_in;
      end
      if (byte_stb && sel_hi) begin
        hi_q <= byte_in;
      end
      if (byte_stb && !sel_hi) begin
        word <= word_t'({hi_q, byte_in});
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a checksummed byte-stream image into code memory and then releases the CPU.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.master     bus,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic              rx_ready_q;
  logic              accept_c;
  logic              asm_stb, asm_hi, asm_clr, cnt_clr;
  word_t             asm_word;
  logic              asm_valid;
  logic [BYTE_W-1:0] asm_chk;

  assign accept_c     = bus.rx_valid && rx_ready_q;
  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = asm_valid;
  assign bus.wr_data  = asm_word;
  assign bus.wr_addr  = word_count;

  word_asm u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (asm_clr),
    .byte_stb   (asm_stb),
    .sel_hi     (asm_hi),
    .byte_in    (bus.rx_data),
    .word       (asm_word),
    .word_valid (asm_valid),
    .chk        (asm_chk)
  );

  // State, length and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      length_q   <= '0;
      rx_ready_q <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      rx_ready_q <= (state_d != DONE);
      cpu_reset  <= (state_d != DONE);
      done       <= (state_d == DONE);
      err        <= (state_d == ERROR);
      // The count steps in the cycle the write strobe is high, so it trails wr_addr usage by one.
      if (cnt_clr) begin
        word_count <= '0;
      end else if (asm_valid) begin
        word_count <= word_count + ADDR_W'(1);
      end
    end
  end

  // Frame parser: next state and per-byte controls.
  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    asm_stb  = 1'b0;
    asm_hi   = 1'b0;
    asm_clr  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      IDLE, ERROR: begin
        if (accept_c && (bus.rx_data == SYNC_BYTE)) begin
          state_d = LEN_HI;
          asm_clr = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept_c) begin
          length_d = ADDR_W'({bus.rx_data, 8'h00});
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept_c) begin
          length_d = length_q | ADDR_W'(bus.rx_data);
          state_d  = ((length_q | ADDR_W'(bus.rx_data)) == '0) ? CHK : DATA_HI;
        end
      end
      DATA_HI: begin
        if (accept_c) begin
          asm_stb = 1'b1;
          asm_hi  = 1'b1;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept_c) begin
          asm_stb = 1'b1;
          state_d = ((word_count + ADDR_W'(1)) == length_q) ? CHK : DATA_HI;
        end
      end
      CHK: begin
        if (accept_c) begin
          state_d = (bus.rx_data == asm_chk) ? DONE : ERROR;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  prog_loader_if #(.ADDR_W(16)) bus ();

  prog_loader #(.ADDR_W(16), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          wide_cnt = 0;
  logic        wr_en_prev = 1'b0;
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      if (wr_en_prev === 1'b1) wide_cnt++;
    end
    wr_en_prev = bus.wr_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   32'(bus.rx_ready), 32'd0);
    check({tag, "_wr_en"},      32'(bus.wr_en),    32'd0);
    check({tag, "_wr_addr"},    32'(bus.wr_addr),  32'd0);
    check({tag, "_wr_data"},    32'(bus.wr_data),  32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset),    32'd1);
    check({tag, "_done"},       32'(done),         32'd0);
    check({tag, "_err"},        32'(err),          32'd0);
    check({tag, "_word_count"}, 32'(word_count),   32'd0);
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    logic [7:0]  ck;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_w;

    reset = 1'b1;
    idle_bus();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_rises", 32'(bus.rx_ready), 32'd1);

    // Nominal two-word load.
    wa_q.delete(); wd_q.delete();
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0);
    check("nom_w0_en",   32'(bus.wr_en),   32'd1);
    check("nom_w0_addr", 32'(bus.wr_addr), 32'h0000);
    check("nom_w0_data", 32'(bus.wr_data), 32'h1234);
    send(8'hAB, 0); send(8'hCD, 0);
    check("nom_w1_en",   32'(bus.wr_en),   32'd1);
    check("nom_w1_addr", 32'(bus.wr_addr), 32'h0001);
    check("nom_w1_data", 32'(bus.wr_data), 32'hABCD);
    check("nom_cpu_rst_before", 32'(cpu_reset), 32'd1);
    send(8'h40, 0);
    idle_bus();
    check("nom_done",      32'(done),          32'd1);
    check("nom_cpu_reset", 32'(cpu_reset),     32'd0);
    check("nom_rx_ready",  32'(bus.rx_ready),  32'd0);
    check("nom_err",       32'(err),           32'd0);
    check("nom_wcount",    32'(word_count),    32'd2);
    #1;
    check("nom_nwrites",   32'(wa_q.size()),   32'd2);

    // DONE holds against a pending sync byte.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (5) @(negedge clk);
    #1;
    check("hold_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("hold_done",     32'(done),         32'd1);
    check("hold_cpu_rst",  32'(cpu_reset),    32'd0);
    check("hold_wcount",   32'(word_count),   32'd2);
    check("hold_nwrites",  32'(wa_q.size()),  32'd2);

    // Checksum failure, then retry.
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h00, 0); send(8'h01, 0); send(8'hFF, 0);
    idle_bus();
    check("bad_err",       32'(err),       32'd1);
    check("bad_done",      32'(done),      32'd0);
    check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("bad_rx_ready",  32'(bus.rx_ready), 32'd1);
    send(8'h3C, 0);
    check("bad_junk_err",  32'(err),       32'd1);
    send(8'hA5, 0);
    check("retry_err_clr", 32'(err),       32'd0);
    send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h01, 0);
    check("retry_addr",    32'(bus.wr_addr), 32'h0000);
    check("retry_data",    32'(bus.wr_data), 32'h0001);
    send(8'h01, 0);
    idle_bus();
    check("retry_done",    32'(done),      32'd1);
    check("retry_err",     32'(err),       32'd0);
    check("retry_cpu_rst", 32'(cpu_reset), 32'd0);

    // Leading junk and a zero-length frame.
    do_reset();
    send(8'h00, 0); send(8'h77, 0);
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    idle_bus();
    #1;
    check("zero_done",    32'(done),         32'd1);
    check("zero_nwrites", 32'(wa_q.size()),  32'd0);
    check("zero_wcount",  32'(word_count),   32'd0);

    // Sixteen words with random valid gaps.
    do_reset();
    ck = 8'h00;
    send(8'hA5, $urandom_range(0, 5));
    send(8'h00, $urandom_range(0, 5));
    send(8'h10, $urandom_range(0, 5));
    for (int i = 0; i < 16; i++) begin
      hi = 8'h10 + 8'(i);
      lo = 8'hC0 ^ 8'(i * 3);
      ck = ck ^ hi ^ lo;
      send(hi, $urandom_range(0, 5));
      send(lo, $urandom_range(0, 5));
    end
    send(ck, $urandom_range(0, 5));
    idle_bus();
    #1;
    check("thr_nwrites", 32'(wa_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_w = {8'h10 + 8'(i), 8'hC0 ^ 8'(i * 3)};
      check($sformatf("thr_addr%0d", i), 32'(wa_q[i]), 32'(i));
      check($sformatf("thr_data%0d", i), 32'(wd_q[i]), 32'(exp_w));
    end
    check("thr_wide_pulses", 32'(wide_cnt),   32'd0);
    check("thr_done",        32'(done),       32'd1);
    check("thr_wcount",      32'(word_count), 32'd16);

    // Reset after the third data byte of a four-word frame.
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    idle_bus();
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_nwrites",   32'(wa_q.size()), 32'd1);
    check("mid_w0_data",   32'(wd_q[0]),     32'h1122);
    check("mid_cpu_reset", 32'(cpu_reset),   32'd1);
    wa_q.delete(); wd_q.delete();
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'h73, 0);
    idle_bus();
    #1;
    check("post_nwrites", 32'(wa_q.size()), 32'd1);
    check("post_addr",    32'(wa_q[0]),     32'h0000);
    check("post_data",    32'(wd_q[0]),     32'hDEAD);
    check("post_done",    32'(done),        32'd1);
    check("post_wide",    32'(wide_cnt),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the code memory and the CPU core.
- Receives a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words sequentially into the code memory write port and holds the CPU in reset until a complete, checksum-verified image is loaded.
- On success it releases cpu_reset, so the beat/pc/ctrl chain starts fetching from address 0.

Parameters:
ADDR_W, 16, width of the code memory address and of the length field.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_valid  input  1  upstream byte available
rx_data  input  8  upstream byte
rx_ready  output  1  loader can accept a byte this cycle
wr_en  output  1  code memory write strobe, one cycle per word
wr_addr  output  ADDR_W  code memory write address
wr_data  output  16  code memory write data
cpu_reset  output  1  held high while the CPU must stay in reset
done  output  1  image loaded and verified
err  output  1  last frame failed its checksum
word_count  output  ADDR_W  number of words written in the current frame

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset, sampled on the clk rising edge.
- Reset values: rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, done=0, err=0, word_count=0. State is IDLE, length=0, chk=0. rx_ready rises the cycle after reset deasserts.
- Byte acceptance: a byte is accepted only when rx_valid && rx_ready at a clk edge.
- rx_ready value: rx_ready=1 in IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK and ERROR. rx_ready=0 in DONE.
- Frame format: SYNC_BYTE, then LEN_HI, then LEN_LO, then LEN words each sent hi byte then lo byte, then CHK. CHK is the XOR of all payload bytes (data bytes only; header excluded).
- State machine:
  - IDLE: bytes other than SYNC_BYTE are discarded. SYNC_BYTE goes to LEN_HI and clears chk, word_count and wr_addr.
  - LEN_HI: latch length[15:8], go to LEN_LO.
  - LEN_LO: latch length[7:0]. If the full length is 0, go to CHK; otherwise go to DATA_HI.
  - DATA_HI: latch hi byte, chk ^= byte, go to DATA_LO.
  - DATA_LO: chk ^= byte. Next cycle wr_en=1 with wr_data={hi,lo} and wr_addr=word_count. On the following cycle word_count and wr_addr increment. Go to CHK when word_count+1 == length, else back to DATA_HI.
  - CHK: if byte == chk, go to DONE; else go to ERROR.
  - DONE: done=1 and cpu_reset=0 from the cycle after the CHK byte is accepted. The state is sticky until reset.
  - ERROR: err=1, cpu_reset stays 1. A SYNC_BYTE clears err and restarts as from IDLE. Other bytes are discarded.
- Write latency: wr_en asserts exactly 1 cycle after the DATA_LO byte is accepted and is high for exactly 1 cycle.
- Back-to-back traffic: the loader sustains one byte per cycle; at most one write is in flight.
- Address wrap: wr_addr wraps modulo 2^ADDR_W. A length of 2^ADDR_W-1 is legal; there is no overrun detection.
- rx_valid gaps: the loader holds its state indefinitely. There is no timeout.
- Reset mid-frame: abort the frame, return to reset values, raise no write strobe, keep cpu_reset=1. Words already written to memory are left in place.
- Inactive write port: wr_data and wr_addr are don't-care when wr_en=0 but are held stable, not toggled.

Decomposition:
- Shared package loader_pkg holds the state encoding (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERROR) and the SYNC_BYTE default.
- One natural sub-module: word_asm, the byte-pair to 16-bit word assembler with running XOR checksum. It takes a byte strobe and a hi/lo select, and outputs word, word_valid and chk.
- The FSM, counters and handshake stay in prog_loader.

Test Plan:
- Nominal load: send A5 00 02 12 34 AB CD 40 (checksum 12^34^AB^CD = 40, so it passes) -> wr_en pulses twice: addr0=1234, addr1=ABCD. word_count=2, done=1, cpu_reset falls the cycle after byte 40, rx_ready=0.
- Checksum fail then retry: send A5 00 01 00 01 FF -> err=1, no done, cpu_reset=1. Then send A5 00 01 00 01 01 -> err clears on A5, addr0=0001, done=1.
- Zero-length and noise: send 00 77 A5 00 00 00 -> leading junk ignored, no wr_en, done=1.
- Throttled stream: rx_valid randomly low for 0–5 cycles over a 16-word frame -> the same 16 writes in order at addresses 0..15, each wr_en exactly 1 cycle wide.
- Reset mid-frame: assert reset after the 3rd data byte of a 4-word frame -> all outputs return to reset values, no further wr_en. A subsequent full frame loads from addr 0.
- Handshake hold: in DONE, keep rx_valid=1 with byte A5 -> rx_ready stays 0, state unchanged, no writes.
